// File: rtl/dm_bus_slave.sv
// Handshaked data-memory responder with wait states, lane-merged stores and extended loads.
// Optional define DM_WRITE_LOG_EN prints one line per successful store.
module dm_bus_slave #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_type,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned Words = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lat_we_q, lat_sign_q;
  logic [1:0]  lat_type_q;
  logic [31:0] lat_addr_q, lat_wdata_q, lat_pc_q;
  logic [31:0] mem_q [Words];
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  // With zero wait states RESP is entered on the accept edge, so the live inputs are used there.
  logic        op_we, op_sign;
  logic [1:0]  op_type;
  logic [31:0] op_addr, op_wdata, op_pc;

  always_comb begin
    if (state_q == StIdle) begin
      op_we    = req_we;
      op_sign  = req_sign;
      op_type  = req_type;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_pc    = req_pc;
    end else begin
      op_we    = lat_we_q;
      op_sign  = lat_sign_q;
      op_type  = lat_type_q;
      op_addr  = lat_addr_q;
      op_wdata = lat_wdata_q;
      op_pc    = lat_pc_q;
    end
  end

  logic [31:0]       offset;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic [4:0]        shamt;
  logic [31:0]       old_word, shifted, load_data, merged;
  logic              acc_err, enter_resp;

  assign offset   = op_addr - BASE_ADDR;
  assign widx     = offset[ADDR_W+1:2];
  assign lane     = offset[1:0];
  assign shamt    = {lane, 3'b000};
  assign old_word = mem_q[widx];
  assign shifted  = old_word >> shamt;

  always_comb begin
    acc_err = (|offset[31:ADDR_W+2]) || (op_type == 2'b11) ||
              ((op_type == 2'b01) && lane[0]) || ((op_type == 2'b00) && (lane != 2'b00));
  end

  always_comb begin
    load_data = 32'h0;
    merged    = old_word;
    unique case (op_type)
      2'b00: begin
        load_data = old_word;
        merged    = op_wdata;
      end
      2'b01: begin
        load_data = {{16{op_sign & shifted[15]}}, shifted[15:0]};
        merged    = (old_word & ~(32'h0000_FFFF << shamt)) | ({16'h0, op_wdata[15:0]} << shamt);
      end
      2'b10: begin
        load_data = {{24{op_sign & shifted[7]}}, shifted[7:0]};
        merged    = (old_word & ~(32'h0000_00FF << shamt)) | ({24'h0, op_wdata[7:0]} << shamt);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_d == StResp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      lat_we_q     <= 1'b0;
      lat_sign_q   <= 1'b0;
      lat_type_q   <= 2'b00;
      lat_addr_q   <= 32'h0;
      lat_wdata_q  <= 32'h0;
      lat_pc_q     <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req_valid) begin
        lat_we_q    <= req_we;
        lat_sign_q  <= req_sign;
        lat_type_q  <= req_type;
        lat_addr_q  <= req_addr;
        lat_wdata_q <= req_wdata;
        lat_pc_q    <= req_pc;
      end
      if (enter_resp) begin
        resp_err_q   <= acc_err;
        resp_rdata_q <= (acc_err || op_we) ? 32'h0 : load_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Words; i++) mem_q[i] <= 32'h0;
    end else if (enter_resp && op_we && !acc_err) begin
      mem_q[widx] <= merged;
    end
  end

`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && op_we && !acc_err) begin
      $display("%0t: @%h: *%h <= %h", $time, op_pc, {op_addr[31:2], 2'b00}, merged);
    end
  end
`endif

  logic unused_pc;
  assign unused_pc = ^op_pc;

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
